if_fetch_sequencer: RTL and testbench

Sequences the instruction-fetch stage of the 5-stage ARM core. It owns the program counter and drives a request/ready handshake into the byte-addressed, little-endian instruction memory. It absorbs hazard-unit freezes with a one-entry skid buffer and handles EXE-stage taken branches, including a branch that arrives while a fetch is still outstanding. Its registered outputs feed the IF/ID pipeline register.

---
 rtl/arm_pkg.sv | 11 +
 rtl/if_skid_buffer.sv | 42 ++++
 rtl/if_fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_if_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Core-wide word width, fetch-state encoding and the NOP encoding.
package arm_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] INSTR_NOP = 32'd0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/if_skid_buffer.sv
// One-entry instr/pc+4 buffer parking a fetched word while IF/ID is frozen.
// Load captures on the next edge; drain and clear empty it, clear also wipes the contents.
module if_skid_buffer
  import arm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic              i_clear,
  input  logic [WORD_W-1:0] i_instr,
  input  logic [WORD_W-1:0] i_pc4,
  output logic [WORD_W-1:0] o_instr,
  output logic [WORD_W-1:0] o_pc4,
  output logic              o_vld
);
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_pc4;
  logic              r_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= INSTR_NOP;
      r_pc4   <= '0;
      r_vld   <= 1'b0;
    end else if (i_clear) begin
      r_instr <= INSTR_NOP;
      r_pc4   <= '0;
      r_vld   <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_vld   <= 1'b1;
    end else if (i_drain) begin
      r_vld   <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_vld   = r_vld;
endmodule

// File: rtl/if_fetch_sequencer.sv
// IF stage: owns the PC, issues req/ready fetches, parks a word across freezes, handles branches.
// Slot updates on the edge ending the ready cycle (1 instr/cycle at zero wait); freeze holds the slot.
module if_fetch_sequencer
  import arm_pkg::*;
#(
  parameter int                MEM_BYTES = 192,
  parameter logic [WORD_W-1:0] RESET_PC  = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_addr,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] pc_out,
  output logic              if_valid
);
  localparam logic [WORD_W-1:0] LP_MEM_END = WORD_W'(MEM_BYTES);

  fetch_state_t      r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_req_addr;
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_pc_out;
  logic              r_valid;

  logic              w_in_range;
  logic              w_req;
  logic              w_accept;
  logic [WORD_W-1:0] w_pc_next;
  logic [WORD_W-1:0] w_branch_tgt;
  logic              w_skid_load;
  logic              w_skid_drain;
  logic              w_skid_vld;
  logic [WORD_W-1:0] w_skid_instr;
  logic [WORD_W-1:0] w_skid_pc4;

  assign w_in_range   = (r_pc < LP_MEM_END);
  assign w_req        = !rst && (((r_state == FETCH) && w_in_range) || (r_state == FLUSH));
  assign w_accept     = w_req && mem_ready;
  assign w_pc_next    = r_pc + 32'd4;
  assign w_branch_tgt = branch_addr & ~32'd3;
  assign w_skid_load  = !branch_taken && (r_state == FETCH) && w_accept && freeze;
  assign w_skid_drain = !branch_taken && (r_state == HOLD) && !freeze;

  if_skid_buffer u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_clear (branch_taken),
    .i_instr (mem_rdata),
    .i_pc4   (w_pc_next),
    .o_instr (w_skid_instr),
    .o_pc4   (w_skid_pc4),
    .o_vld   (w_skid_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
      r_instr    <= INSTR_NOP;
      r_pc_out   <= '0;
      r_valid    <= 1'b0;
    end else if (branch_taken) begin
      r_valid <= 1'b0;
      r_pc    <= w_branch_tgt;
      case (r_state)
        // An unanswered request must still be drained before fetching the target.
        FETCH: begin
          if (w_req && !mem_ready) begin
            r_state    <= FLUSH;
            r_req_addr <= r_pc;
          end else begin
            r_state <= FETCH;
          end
        end
        HOLD:    r_state <= FETCH;
        default: r_state <= mem_ready ? FETCH : FLUSH;
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (w_accept) begin
            r_pc <= w_pc_next;
            if (freeze) begin
              r_state <= HOLD;
            end else begin
              r_instr  <= mem_rdata;
              r_pc_out <= w_pc_next;
              r_valid  <= 1'b1;
            end
          end else if (!freeze) begin
            r_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!freeze) begin
            r_instr  <= w_skid_instr;
            r_pc_out <= w_skid_pc4;
            r_valid  <= w_skid_vld;
            r_state  <= FETCH;
          end
        end
        default: begin
          if (mem_ready) r_state <= FETCH;
        end
      endcase
    end
  end

  assign mem_req     = w_req;
  assign mem_addr    = (r_state == FLUSH) ? r_req_addr : r_pc;
  assign instruction = r_instr;
  assign pc_out      = r_pc_out;
  assign if_valid    = r_valid;
endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Self-checking bench: directed scenarios then randomized freeze/branch/wait-state traffic,
// compared each cycle against an address-level reference model of the fetch stage.
module tb_if_fetch_sequencer;
  localparam int MEM_BYTES = 192;
  localparam int N_WORDS   = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        if_valid;

  if_fetch_sequencer #(.MEM_BYTES(MEM_BYTES), .RESET_PC(32'd0)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .if_valid     (if_valid)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_w [N_WORDS];
  int n_checks = 0;
  int n_errors = 0;

  // Memory responder state
  bit mem_busy;
  int wait_left;
  int wait_lo, wait_hi;

  // Reference model: next fetch address, parked-word address, pending drain address, slot
  logic [31:0] m_pc, m_haddr, m_faddr, m_instr, m_pcout;
  bit          m_held, m_fl, m_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a < MEM_BYTES) ? mem_w[a >> 2] : 32'hDEAD_BEEF;
  endfunction

  function automatic bit m_req();
    return m_fl || (!m_held && (m_pc < MEM_BYTES));
  endfunction

  function automatic logic [31:0] m_addr();
    return m_fl ? m_faddr : m_pc;
  endfunction

  task automatic m_reset();
    m_pc = 32'd0; m_haddr = 32'd0; m_faddr = 32'd0;
    m_instr = 32'd0; m_pcout = 32'd0;
    m_held = 1'b0; m_fl = 1'b0; m_v = 1'b0;
  endtask

  task automatic check_outputs();
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_req()});
    if (m_req()) chk("mem_addr", mem_addr, m_addr());
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
    if (m_v) begin
      chk("instruction", instruction, m_instr);
      chk("pc_out", pc_out, m_pcout);
    end
  endtask

  // One clock: check, drive inputs and memory response, advance model, move to next negedge.
  task automatic step(input bit frz, input bit br, input logic [31:0] baddr);
    bit rdy;
    bit req;
    check_outputs();
    freeze = frz;
    branch_taken = br;
    branch_addr = baddr;
    rdy = 1'b0;
    if (mem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        wait_left = $urandom_range(wait_hi, wait_lo);
      end
      if (wait_left == 0) begin
        rdy = 1'b1;
        mem_busy = 1'b0;
      end else begin
        wait_left--;
      end
    end
    mem_ready = rdy;
    mem_rdata = rdy ? word_at(mem_addr) : $urandom;

    req = m_req();
    if (br) begin
      m_v = 1'b0;
      if (m_fl) m_fl = !rdy;
      else if (!m_held && req && !rdy) begin
        m_fl = 1'b1;
        m_faddr = m_pc;
      end
      m_held = 1'b0;
      m_pc = baddr & 32'hFFFF_FFFC;
    end else if (m_fl) begin
      if (rdy) m_fl = 1'b0;
    end else if (m_held) begin
      if (!frz) begin
        m_v = 1'b1;
        m_instr = word_at(m_haddr);
        m_pcout = m_haddr + 32'd4;
        m_held = 1'b0;
      end
    end else if (req && rdy) begin
      if (!frz) begin
        m_v = 1'b1;
        m_instr = word_at(m_pc);
        m_pcout = m_pc + 32'd4;
      end else begin
        m_held = 1'b1;
        m_haddr = m_pc;
      end
      m_pc = m_pc + 32'd4;
    end else if (!frz) begin
      m_v = 1'b0;
    end

    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Asserts rst away from any clock edge and checks outputs before the next edge.
  task automatic do_reset();
    rst = 1'b1;
    freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    mem_busy = 1'b0; wait_left = 0;
    m_reset();
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < N_WORDS; i++) mem_w[i] = $urandom;
    wait_lo = 0; wait_hi = 0;
    do_reset();

    // Zero-wait streaming, then a 3-cycle freeze while the word at 8 returns
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // Two wait states, branch to 0x24 in the first wait cycle of a request
    wait_lo = 2; wait_hi = 2;
    begin
      int k = 0;
      while (!(m_req() && !mem_busy) && k < 20) begin
        step(0, 0, 0);
        k++;
      end
      chk("sync_new_request", {31'd0, (m_req() && !mem_busy)}, 32'd1);
    end
    step(0, 1, 32'h24);
    for (int i = 0; i < 8; i++) step(0, 0, 0);

    // Branch together with freeze to an unaligned target
    wait_lo = 0; wait_hi = 0;
    step(1, 1, 32'h8B);
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // Last word of memory, run off the end, recover with a branch to 0
    step(0, 1, 32'hBC);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("end_pc_stalled", {31'd0, mem_req}, 32'd0);
    step(0, 1, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // Reset pulsed while a word is parked
    step(0, 0, 0);
    step(1, 0, 0);
    chk("hold_reached_slot_valid", {31'd0, if_valid}, 32'd1);
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ba;
      if (i % 200 == 0) begin
        wait_lo = 0;
        wait_hi = $urandom_range(3, 0);
      end
      ba = ($urandom_range(99, 0) < 85) ? 32'($urandom_range(MEM_BYTES + 8, 0)) : $urandom;
      step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 7, ba);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
